// File: rtl/odu_frame_sync_monitor.sv
// Receive-side ODU monitor: frame alignment (HUNT/PRESYNC/SYNC), multiframe lock and error counters.
// State | meaning: HUNT = searching for FS; PRESYNC = confirming FS period; SYNC = aligned, checking.
module odu_frame_sync_monitor #(
  parameter int WORDS_PER_ROW = 80,
  parameter int ROWS          = 4,
  parameter int IF_LIM        = 3,
  parameter int OOF_LIM       = 5,
  parameter int MF_GOOD       = 2,
  parameter int MF_BAD        = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [383:0] i_data,
  input  logic         i_fs,
  input  logic         i_rs,
  input  logic [7:0]   i_mfas,
  input  logic         i_clr_cnt,
  output logic         o_in_frame,
  output logic         o_mf_lock,
  output logic [15:0]  o_fs_err_cnt,
  output logic [15:0]  o_rs_err_cnt,
  output logic [15:0]  o_mfas_err_cnt,
  output logic [31:0]  o_frame_cnt
);

  localparam int WW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;

  state_t         state_q, state_d;
  logic [WW-1:0]  word_q, word_d;
  logic [RW-1:0]  row_q, row_d;
  logic [7:0]     good_cnt_q, good_cnt_d;
  logic [7:0]     bad_cnt_q, bad_cnt_d;
  logic [7:0]     mf_good_q, mf_good_d;
  logic [7:0]     mf_bad_q, mf_bad_d;
  logic [7:0]     prev_mfas_q, prev_mfas_d;
  logic           mf_first_q, mf_first_d;
  logic           in_frame_q, in_frame_d;
  logic           mf_lock_q, mf_lock_d;
  logic [15:0]    fs_err_q, fs_err_d;
  logic [15:0]    rs_err_q, rs_err_d;
  logic [15:0]    mfas_err_q, mfas_err_d;
  logic [31:0]    frame_cnt_q, frame_cnt_d;

  logic           at_fs;
  logic           inc_fs, inc_rs, inc_mf, inc_fc;
  logic [7:0]     good_inc, bad_inc, mf_good_inc, mf_bad_inc;

  // The payload is carried for the downstream consumer only; nothing here inspects it.
  logic unused_data;
  assign unused_data = ^i_data;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    row_d       = row_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    mf_good_d   = mf_good_q;
    mf_bad_d    = mf_bad_q;
    prev_mfas_d = prev_mfas_q;
    mf_first_d  = mf_first_q;
    mf_lock_d   = mf_lock_q;
    inc_fs      = 1'b0;
    inc_rs      = 1'b0;
    inc_mf      = 1'b0;
    inc_fc      = 1'b0;
    at_fs       = (word_q == '0) && (row_q == '0);
    good_inc    = good_cnt_q + 8'd1;
    bad_inc     = bad_cnt_q + 8'd1;
    mf_good_inc = (mf_good_q >= 8'(MF_GOOD)) ? mf_good_q : mf_good_q + 8'd1;
    mf_bad_inc  = (mf_bad_q >= 8'(MF_BAD)) ? mf_bad_q : mf_bad_q + 8'd1;

    if (i_valid) begin
      if (word_q == WW'(WORDS_PER_ROW - 1)) begin
        word_d = '0;
        row_d  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
      end else begin
        word_d = word_q + WW'(1);
      end

      case (state_q)
        HUNT: begin
          if (i_fs) begin
            state_d    = PRESYNC;
            word_d     = WW'(1);
            row_d      = '0;
            good_cnt_d = 8'd1;
          end
        end
        PRESYNC: begin
          if (at_fs) begin
            if (i_fs) begin
              good_cnt_d = good_inc;
              if (good_inc >= 8'(IF_LIM)) begin
                state_d    = SYNC;
                bad_cnt_d  = '0;
                mf_first_d = 1'b1;
              end
            end else begin
              state_d = HUNT;
            end
          end else if (i_fs) begin
            word_d     = WW'(1);
            row_d      = '0;
            good_cnt_d = 8'd1;
          end
        end
        SYNC: begin
          if ((word_q == '0) != i_rs) inc_rs = 1'b1;
          if (at_fs) begin
            if (i_fs) begin
              bad_cnt_d   = '0;
              inc_fc      = 1'b1;
              prev_mfas_d = i_mfas;
              if (mf_first_q) begin
                mf_first_d = 1'b0;
              end else if (i_mfas == prev_mfas_q + 8'd1) begin
                mf_bad_d  = '0;
                mf_good_d = mf_good_inc;
                if (mf_good_inc >= 8'(MF_GOOD)) mf_lock_d = 1'b1;
              end else begin
                inc_mf    = 1'b1;
                mf_good_d = '0;
                mf_bad_d  = mf_bad_inc;
                if (mf_bad_inc >= 8'(MF_BAD)) mf_lock_d = 1'b0;
              end
            end else begin
              inc_fs    = 1'b1;
              bad_cnt_d = bad_inc;
              if (bad_inc >= 8'(OOF_LIM)) state_d = HUNT;
            end
          end else if (i_fs) begin
            inc_fs = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Loss of frame drops multiframe lock on the same edge
    if ((state_q == SYNC) && (state_d != SYNC)) begin
      mf_lock_d = 1'b0;
      mf_good_d = '0;
      mf_bad_d  = '0;
    end

    in_frame_d  = (state_d == SYNC);
    fs_err_d    = i_clr_cnt ? '0 : (inc_fs && fs_err_q != 16'hFFFF) ? fs_err_q + 16'd1 : fs_err_q;
    rs_err_d    = i_clr_cnt ? '0 : (inc_rs && rs_err_q != 16'hFFFF) ? rs_err_q + 16'd1 : rs_err_q;
    mfas_err_d  = i_clr_cnt ? '0 : (inc_mf && mfas_err_q != 16'hFFFF) ? mfas_err_q + 16'd1 : mfas_err_q;
    frame_cnt_d = i_clr_cnt ? '0 : inc_fc ? frame_cnt_q + 32'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HUNT;
      word_q      <= '0;
      row_q       <= '0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      mf_good_q   <= '0;
      mf_bad_q    <= '0;
      prev_mfas_q <= '0;
      mf_first_q  <= 1'b0;
      in_frame_q  <= 1'b0;
      mf_lock_q   <= 1'b0;
      fs_err_q    <= '0;
      rs_err_q    <= '0;
      mfas_err_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      row_q       <= row_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      mf_good_q   <= mf_good_d;
      mf_bad_q    <= mf_bad_d;
      prev_mfas_q <= prev_mfas_d;
      mf_first_q  <= mf_first_d;
      in_frame_q  <= in_frame_d;
      mf_lock_q   <= mf_lock_d;
      fs_err_q    <= fs_err_d;
      rs_err_q    <= rs_err_d;
      mfas_err_q  <= mfas_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_in_frame     = in_frame_q;
  assign o_mf_lock      = mf_lock_q;
  assign o_fs_err_cnt   = fs_err_q;
  assign o_rs_err_cnt   = rs_err_q;
  assign o_mfas_err_cnt = mfas_err_q;
  assign o_frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_odu_frame_sync_monitor.sv
// Frame-level directed vectors for odu_frame_sync_monitor; each record is one 320-word frame
// followed by the expected status/counter values once the frame has been consumed.
module tb_odu_frame_sync_monitor;

  localparam int WPR = 80;
  localparam int FRAME_WORDS = WPR * 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_valid = 1'b0;
  logic [383:0] i_data = '0;
  logic         i_fs = 1'b0;
  logic         i_rs = 1'b0;
  logic [7:0]   i_mfas = '0;
  logic         i_clr_cnt = 1'b0;
  logic         o_in_frame, o_mf_lock;
  logic [15:0]  o_fs_err_cnt, o_rs_err_cnt, o_mfas_err_cnt;
  logic [31:0]  o_frame_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int fnum = 1;

  odu_frame_sync_monitor dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_fs(i_fs), .i_rs(i_rs),
    .i_mfas(i_mfas), .i_clr_cnt(i_clr_cnt), .o_in_frame(o_in_frame), .o_mf_lock(o_mf_lock),
    .o_fs_err_cnt(o_fs_err_cnt), .o_rs_err_cnt(o_rs_err_cnt), .o_mfas_err_cnt(o_mfas_err_cnt),
    .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst_before;   // pulse reset before this frame
    bit fs;           // FS present at word 0
    int extra_fs;     // word index of an additional FS, -1 none
    int rs_flip;      // word index whose RS is inverted, -1 none
    int clr;          // word index carrying i_clr_cnt, -1 none
    int mfas;         // forced MFAS value, -1 = generator count
    bit gaps;         // random idle cycles between words
    bit e_in, e_lock;
    int e_fs, e_rs, e_mf, e_fc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rb, bit fs, int xfs, int rsf, int clr, int mf, bit gaps,
                              bit e_in, bit e_lock, int e_fs, int e_rs, int e_mf, int e_fc);
    vec_t v;
    v.rst_before = rb; v.fs = fs; v.extra_fs = xfs; v.rs_flip = rsf; v.clr = clr;
    v.mfas = mf; v.gaps = gaps; v.e_in = e_in; v.e_lock = e_lock;
    v.e_fs = e_fs; v.e_rs = e_rs; v.e_mf = e_mf; v.e_fc = e_fc;
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, bit e_in, bit e_lock, int e_fs, int e_rs, int e_mf, int e_fc);
    chk({tag, " in_frame"}, 32'(o_in_frame), 32'(e_in));
    chk({tag, " mf_lock"}, 32'(o_mf_lock), 32'(e_lock));
    chk({tag, " fs_err"}, 32'(o_fs_err_cnt), 32'(e_fs));
    chk({tag, " rs_err"}, 32'(o_rs_err_cnt), 32'(e_rs));
    chk({tag, " mfas_err"}, 32'(o_mfas_err_cnt), 32'(e_mf));
    chk({tag, " frame_cnt"}, o_frame_cnt, 32'(e_fc));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    i_valid = 1'b0;
    i_fs = 1'($urandom);
    i_rs = 1'($urandom);
    i_mfas = 8'($urandom);
    i_clr_cnt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_frame(vec_t v);
    for (int k = 0; k < FRAME_WORDS; k++) begin
      if (v.gaps) begin
        for (int g = 0; g < 3; g++) if ($urandom_range(0, 9) < 3) idle_cycle();
      end
      @(negedge clk);
      i_valid   = 1'b1;
      i_fs      = (v.fs && k == 0) || (k == v.extra_fs);
      i_rs      = ((k % WPR) == 0) ^ (k == v.rs_flip);
      i_mfas    = (v.mfas < 0) ? 8'(fnum) : 8'(v.mfas);
      i_clr_cnt = (k == v.clr);
      i_data    = {12{$urandom}};
    end
    fnum++;
    @(negedge clk);
    i_valid = 1'b0;
    i_fs = 1'b0;
    i_rs = 1'b0;
    i_clr_cnt = 1'b0;
  endtask

  initial begin
    // rb fs xfs  rsf  clr mfas gap | in lk fs rs mf fc
    add(0, 1, -1,  -1,  -1, -1, 0,  0, 0, 0, 0, 0, 0);   // F1  HUNT->PRESYNC
    add(0, 1, -1,  -1,  -1, -1, 0,  0, 0, 0, 0, 0, 0);   // F2
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 0, 0, 0, 0, 0);   // F3  SYNC
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 0, 0, 0, 0, 1);   // F4  MFAS load only
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 0, 0, 0, 0, 2);
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 1, 0, 0, 0, 3);   // F6  lock
    add(0, 0, -1,  -1,  -1, -1, 0,  1, 1, 1, 0, 0, 3);   // F7  single FS miss
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 1, 1, 0, 1, 4);   // F8  MFAS skipped one
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 1, 1, 0, 1, 5);
    add(0, 1, -1,  85,  -1, -1, 0,  1, 1, 1, 1, 1, 6);   // spurious RS
    add(0, 1, -1, 160,  -1, -1, 0,  1, 1, 1, 2, 1, 7);   // missing RS
    add(0, 1, -1,  -1,  -1,  0, 0,  1, 1, 1, 2, 2, 8);   // MFAS forced 0
    add(0, 1, -1,  -1,  -1,  0, 0,  1, 1, 1, 2, 3, 9);
    add(0, 1, -1,  -1,  -1,  0, 0,  1, 0, 1, 2, 4, 10);  // 3rd bad drops lock
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 0, 1, 2, 5, 11);
    add(0, 1, 200, -1,  -1, -1, 0,  1, 0, 2, 2, 5, 12);  // stray FS in SYNC
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 1, 2, 2, 5, 13);
    add(0, 0, -1,  -1,  -1, -1, 0,  1, 1, 3, 2, 5, 13);  // 5 missing FS
    add(0, 0, -1,  -1,  -1, -1, 0,  1, 1, 4, 2, 5, 13);
    add(0, 0, -1,  -1,  -1, -1, 0,  1, 1, 5, 2, 5, 13);
    add(0, 0, -1,  -1,  -1, -1, 0,  1, 1, 6, 2, 5, 13);
    add(0, 0, -1,  -1,  -1, -1, 0,  0, 0, 7, 2, 5, 13);  // OOF
    add(0, 1, -1,  -1,  -1, -1, 0,  0, 0, 7, 2, 5, 13);
    add(0, 1, -1,  -1,  -1, -1, 0,  0, 0, 7, 2, 5, 13);
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 0, 7, 2, 5, 13);  // relock
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 0, 7, 2, 5, 14);
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 0, 7, 2, 5, 15);
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 1, 7, 2, 5, 16);
    add(0, 1, -1,  10,  10, -1, 0,  1, 1, 0, 0, 0, 0);   // clear beats RS error
    add(0, 1, -1,  -1,   0, -1, 0,  1, 1, 0, 0, 0, 0);   // clear beats frame inc
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 1, 0, 0, 0, 1);
    add(1, 1, -1,  -1,  -1, -1, 1,  0, 0, 0, 0, 0, 0);   // gapped valid
    add(0, 1, -1,  -1,  -1, -1, 1,  0, 0, 0, 0, 0, 0);
    add(0, 1, -1,  -1,  -1, -1, 1,  1, 0, 0, 0, 0, 0);
    add(0, 1, -1,  -1,  -1, -1, 1,  1, 0, 0, 0, 0, 1);
    add(0, 1, -1,  -1,  -1, -1, 1,  1, 0, 0, 0, 0, 2);
    add(0, 1, -1,  -1,  -1, -1, 1,  1, 1, 0, 0, 0, 3);
    add(1, 1, -1,  -1,  -1, -1, 0,  0, 0, 0, 0, 0, 0);   // PRESYNC miss -> HUNT
    add(0, 0, -1,  -1,  -1, -1, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, -1,  -1,  -1, -1, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, -1,  -1,  -1, -1, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 0, 0, 0, 0, 0);
    add(1, 1, -1,  -1,  -1, -1, 0,  0, 0, 0, 0, 0, 0);   // PRESYNC realign
    add(0, 1, 100, -1,  -1, -1, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, -1,  -1,  -1, -1, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, -1,  -1,  -1, -1, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, -1,  -1,  -1, -1, 0,  1, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_all("post_reset", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) do_reset();
      send_frame(tbl[i]);
      chk_all($sformatf("vec%0d", i), tbl[i].e_in, tbl[i].e_lock, tbl[i].e_fs,
              tbl[i].e_rs, tbl[i].e_mf, tbl[i].e_fc);
    end

    // Build up nonzero counters in SYNC, then reset asynchronously mid-row
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_fs = (k == 0);
      i_rs = 1'b1;
      i_mfas = 8'(fnum);
      i_clr_cnt = 1'b0;
    end
    @(negedge clk);
    i_valid = 1'b0;
    chk("pre_rst in_frame", 32'(o_in_frame), 32'd1);
    chk("pre_rst rs_err", 32'(o_rs_err_cnt), 32'd44);
    chk("pre_rst frame_cnt", o_frame_cnt, 32'd1);
    #2 rst = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();
    idle_cycle();
    chk_all("after_async_rst", 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
